// File: rtl/eth_preamble_ifg_tx.sv
// eth_preamble_ifg_tx
//
// Wraps an Ethernet frame (payload + FCS, supplied by the CRC stage) with a
// preamble of PREAMBLE_LEN 0x55 bytes and an 0xD5 SFD. After each frame it
// enforces IFG_BYTES idle cycles before the next frame may start. Drives a
// byte-wide GMII-style transmit interface.
//
// Parameters:
//   IFG_BYTES    idle cycles after each frame (1..255)
//   PREAMBLE_LEN number of 0x55 bytes before the SFD (1..7)
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_sof/in_vld/in_data/in_eof/in_rdy
//                     upstream byte stream; a byte moves on in_vld && in_rdy.
//                     Upstream holds its inputs stable while in_vld && !in_rdy.
//   gmii_txd/gmii_tx_en/gmii_tx_er
//                     registered transmit byte, enable and error
//   tx_busy           high whenever the state machine is not idle
//   frame_done        one-cycle pulse on the last inter-frame-gap cycle
//
// Build option:
//   ETH_TX_UNDERRUN_ERR_EN  when defined, an upstream underrun during the
//                           frame body is flagged with one tx_er cycle before
//                           the gap; otherwise the frame simply ends and
//                           gmii_tx_er is tied low.

module eth_preamble_ifg_tx #(
    parameter int IFG_BYTES    = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_sof,
    input  logic       in_vld,
    input  logic [7:0] in_data,
    input  logic       in_eof,
    output logic       in_rdy,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       tx_busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        IFG  = 3'd4
    } state_t;

    localparam logic [2:0] PRE_LAST = 3'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    // The state names the decision being made this cycle; its result lands in
    // the output registers at the next edge. So the IDLE cycle that sees SOF
    // already loads the first preamble byte, and the SFD state loads 0xD5
    // while DATA accepts the first frame byte one cycle later, which keeps
    // tx_en free of holes.
    state_t     state_reg,   state_next;
    logic [2:0] pre_cnt_reg, pre_cnt_next;   // preamble bytes already loaded
    logic [7:0] ifg_cnt_reg, ifg_cnt_next;   // gap cycles already loaded
    logic [7:0] txd_reg,     txd_next;
    logic       tx_en_reg,   tx_en_next;
    logic       done_reg,    done_next;
`ifdef ETH_TX_UNDERRUN_ERR_EN
    logic       tx_er_reg,   tx_er_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pre_cnt_reg <= 3'd0;
            ifg_cnt_reg <= 8'd0;
            txd_reg     <= 8'h00;
            tx_en_reg   <= 1'b0;
            done_reg    <= 1'b0;
`ifdef ETH_TX_UNDERRUN_ERR_EN
            tx_er_reg   <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            pre_cnt_reg <= pre_cnt_next;
            ifg_cnt_reg <= ifg_cnt_next;
            txd_reg     <= txd_next;
            tx_en_reg   <= tx_en_next;
            done_reg    <= done_next;
`ifdef ETH_TX_UNDERRUN_ERR_EN
            tx_er_reg   <= tx_er_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        pre_cnt_next = pre_cnt_reg;
        ifg_cnt_next = ifg_cnt_reg;
        txd_next     = 8'h00;
        tx_en_next   = 1'b0;
        done_next    = 1'b0;
        in_rdy       = 1'b0;
`ifdef ETH_TX_UNDERRUN_ERR_EN
        tx_er_next   = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                // Bytes without SOF are leftovers of a truncated frame: eat them.
                in_rdy = in_vld && !in_sof;
                if (in_vld && in_sof) begin
                    txd_next     = PRE_BYTE;
                    tx_en_next   = 1'b1;
                    pre_cnt_next = 3'd1;
                    state_next   = (PREAMBLE_LEN == 1) ? SFD : PRE;
                end
            end

            PRE: begin
                txd_next     = PRE_BYTE;
                tx_en_next   = 1'b1;
                pre_cnt_next = pre_cnt_reg + 3'd1;
                if (pre_cnt_reg == PRE_LAST) begin
                    state_next = SFD;
                end
            end

            SFD: begin
                txd_next     = SFD_BYTE;
                tx_en_next   = 1'b1;
                pre_cnt_next = 3'd0;
                state_next   = DATA;
            end

            DATA: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    txd_next   = in_data;
                    tx_en_next = 1'b1;
                    if (in_eof) begin
                        ifg_cnt_next = 8'd0;
                        state_next   = IFG;
                    end
                end else begin
                    // Underrun: the frame cannot continue.
`ifdef ETH_TX_UNDERRUN_ERR_EN
                    tx_en_next = 1'b1;
                    tx_er_next = 1'b1;
`endif
                    ifg_cnt_next = 8'd0;
                    state_next   = IFG;
                end
            end

            IFG: begin
                if (ifg_cnt_reg == IFG_LAST) begin
                    done_next    = 1'b1;
                    ifg_cnt_next = 8'd0;
                    state_next   = IDLE;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (rst) begin
            in_rdy = 1'b0;
        end
    end

    assign gmii_txd   = txd_reg;
    assign gmii_tx_en = tx_en_reg;
    assign frame_done = done_reg;
    assign tx_busy    = (state_reg != IDLE);
`ifdef ETH_TX_UNDERRUN_ERR_EN
    assign gmii_tx_er = tx_er_reg;
`else
    assign gmii_tx_er = 1'b0;
`endif

endmodule

// File: tb/tb_eth_preamble_ifg_tx.sv
// Testbench for eth_preamble_ifg_tx: a per-cycle vector table around a
// one-byte frame (default and 3-byte-preamble instances side by side), then
// hand-written sequences for long frames, back-to-back frames, underrun and
// a mid-frame reset. Honours ETH_TX_UNDERRUN_ERR_EN when defined.

`timescale 1ns/1ps

module tb_eth_preamble_ifg_tx;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       in_sof  = 1'b0;
    logic       in_vld  = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_eof  = 1'b0;

    logic       in_rdy, gmii_tx_en, gmii_tx_er, tx_busy, frame_done;
    logic [7:0] gmii_txd;
    logic       in_rdy2, gmii_tx_en2, gmii_tx_er2, tx_busy2, frame_done2;
    logic [7:0] gmii_txd2;

    int total  = 0;
    int passed = 0;

`ifdef ETH_TX_UNDERRUN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    eth_preamble_ifg_tx #(.IFG_BYTES(12), .PREAMBLE_LEN(7)) dut (
        .clk(clk), .rst(rst),
        .in_sof(in_sof), .in_vld(in_vld), .in_data(in_data), .in_eof(in_eof),
        .in_rdy(in_rdy),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .tx_busy(tx_busy), .frame_done(frame_done)
    );

    eth_preamble_ifg_tx #(.IFG_BYTES(12), .PREAMBLE_LEN(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_sof(in_sof), .in_vld(in_vld), .in_data(in_data), .in_eof(in_eof),
        .in_rdy(in_rdy2),
        .gmii_txd(gmii_txd2), .gmii_tx_en(gmii_tx_en2), .gmii_tx_er(gmii_tx_er2),
        .tx_busy(tx_busy2), .frame_done(frame_done2)
    );

    // ---------------- capture and helpers ----------------
    logic [7:0] cap_txd[$];
    logic       cap_en[$];
    logic       cap_er[$];
    logic       cap_done[$];
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cap_clear();
        cap_txd.delete(); cap_en.delete(); cap_er.delete(); cap_done.delete();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cap_txd.push_back(gmii_txd);
        cap_en.push_back(gmii_tx_en);
        cap_er.push_back(gmii_tx_er);
        cap_done.push_back(frame_done);
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
        repeat (n) cycle();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof);
        int guard;
        guard = 0;
        in_vld = 1'b1; in_sof = sof; in_data = d; in_eof = eof;
        #1;
        while (in_rdy !== 1'b1 && guard < 400) begin
            cycle();
            #1;
            guard++;
        end
        if (guard >= 400) begin
            total++;
            $display("FAIL handshake_timeout: in_rdy low for %0d cycles, required high within 400", guard);
        end
        cycle();
        in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
    endtask

    task automatic send_frame(input int n, input logic [7:0] base, output int sof_idx);
        sof_idx = cap_en.size();
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), i == 0, i == n - 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cap_clear();
    endtask

    function automatic int find_en(input int from);
        for (int i = from; i < cap_en.size(); i++) if (cap_en[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int find_done(input int from);
        for (int i = from; i < cap_done.size(); i++) if (cap_done[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int run_len(input int from);
        int n = 0;
        for (int i = from; i < cap_en.size(); i++) begin
            if (cap_en[i] !== 1'b1) break;
            n++;
        end
        return n;
    endfunction

    function automatic int count_ones(input bit use_er);
        int n = 0;
        for (int i = 0; i < cap_en.size(); i++)
            if ((use_er ? cap_er[i] : cap_done[i]) === 1'b1) n++;
        return n;
    endfunction

    task automatic exp_pre(input int len);
        exp_q.delete();
        repeat (len) exp_q.push_back(9'h155);
        exp_q.push_back(9'h1D5);
    endtask

    task automatic exp_data(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, base + 8'(i)});
    endtask

    task automatic exp_low(input int n);
        repeat (n) exp_q.push_back(9'h000);
    endtask

    // Compares captured {tx_en, txd} from index start against exp_q.
    task automatic check_stream(input string name, input int start);
        int nmis;
        int first;
        logic [8:0] a;
        logic [8:0] fa;
        nmis = 0; first = -1; fa = 9'h000;
        for (int i = 0; i < exp_q.size(); i++) begin
            int k;
            k = start + i;
            a = (k >= 0 && k < cap_en.size()) ? {cap_en[k], cap_txd[k]} : 9'bx;
            if (a !== exp_q[i]) begin
                if (first < 0) begin first = i; fa = a; end
                nmis++;
            end
        end
        if (first >= 0)
            $display("  %s: first difference at offset %0d: {en,txd}=%03h, expected %03h",
                     name, first, fa, exp_q[first]);
        chk({name, "_mismatches"}, nmis, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       sof;
        logic       vld;
        logic [7:0] data;
        logic       eof;
        logic       rdy;
        logic [7:0] txd;
        logic       en;
        logic       er;
        logic       busy;
        logic       done;
        logic [7:0] txd3;
        logic       en3;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [7:0] d,
                                input logic e, input logic rdy, input logic [7:0] txd,
                                input logic en, input logic er, input logic busy,
                                input logic done, input logic [7:0] txd3, input logic en3);
        vec_t t;
        t.rst = r; t.sof = s; t.vld = v; t.data = d; t.eof = e;
        t.rdy = rdy; t.txd = txd; t.en = en; t.er = er; t.busy = busy; t.done = done;
        t.txd3 = txd3; t.en3 = en3;
        return t;
    endfunction

    vec_t tbl[24];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, s3, e1, sx, rst_idx;
        logic [7:0] t3;
        logic       e3;

        // Columns: rst sof vld data eof | rdy txd en er busy done | txd(PRE=3) en(PRE=3)
        // Outputs are those seen after the clock edge that samples the inputs.
        tbl[0] = mk(1, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0,  8'h00, 0);
        tbl[1] = mk(0, 0, 1, 8'h11, 0,  1, 8'h00, 0, 0, 0, 0,  8'h00, 0);
        for (int i = 2; i <= 9; i++) begin
            t3 = (i <= 4) ? 8'h55 : (i == 5) ? 8'hD5 : (i == 6) ? 8'hA5 : 8'h00;
            e3 = (i <= 6);
            tbl[i] = mk(0, 1, 1, 8'hA5, 1,  0, (i == 9) ? 8'hD5 : 8'h55, 1, 0, 1, 0,  t3, e3);
        end
        tbl[10] = mk(0, 1, 1, 8'hA5, 1,  1, 8'hA5, 1, 0, 1, 0,  8'h00, 0);
        for (int i = 11; i <= 21; i++)
            tbl[i] = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 1, 0,  8'h00, 0);
        tbl[22] = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1,  8'h00, 0);
        tbl[23] = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0,  8'h00, 0);

        for (int i = 0; i < 24; i++) begin
            rst = tbl[i].rst; in_sof = tbl[i].sof; in_vld = tbl[i].vld;
            in_data = tbl[i].data; in_eof = tbl[i].eof;
            #1;
            chk($sformatf("vec%0d_in_rdy", i), in_rdy, tbl[i].rdy);
            cycle();
            chk($sformatf("vec%0d_out", i),
                {gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_done, gmii_txd2, gmii_tx_en2},
                {tbl[i].txd, tbl[i].en, tbl[i].er, tbl[i].busy, tbl[i].done, tbl[i].txd3, tbl[i].en3});
        end
        $display("table: %0d vectors applied", 24);

        // 64-byte frame after reset release
        do_reset();
        send_frame(64, 8'h00, s);
        idle(20);
        chk("f64_first_preamble", {cap_en[s], cap_txd[s]}, 9'h155);
        exp_pre(7); exp_data(8'h00, 64); exp_low(12);
        check_stream("f64_stream", s);
        chk("f64_en_run", run_len(s), 72);
        chk("f64_done_offset", find_done(s) - s, 83);
        chk("f64_done_count", count_ones(1'b0), 1);
        $display("frame64: start index %0d", s);

        // Two back-to-back 60-byte frames, second SOF waiting through the gap
        do_reset();
        send_frame(60, 8'h10, s);
        send_frame(60, 8'h80, sx);
        idle(20);
        chk("b2b_first_en_run", run_len(s), 68);
        e1 = s + run_len(s);
        s2 = find_en(e1);
        chk("b2b_gap_low_cycles", s2 - e1, 12);
        exp_pre(7); exp_data(8'h80, 60); exp_low(12);
        check_stream("b2b_second_stream", s2);
        chk("b2b_done_count", count_ones(1'b0), 2);
        $display("back_to_back: second frame starts %0d cycles after first ends", s2 - e1);

        // Underrun after 10 data bytes, then stray bytes, then a fresh frame
        do_reset();
        s = cap_en.size();
        for (int i = 0; i < 10; i++) send_byte(8'h20 + 8'(i), i == 0, 1'b0);
        idle(3);
        for (int i = 10; i < 18; i++) send_byte(8'h20 + 8'(i), 1'b0, i == 17);
        idle(3);
        send_frame(1, 8'hC3, sx);
        idle(16);
        exp_pre(7); exp_data(8'h20, 10);
        exp_q.push_back(ERR_EN ? 9'h100 : 9'h000);
        exp_low(12);
        check_stream("underrun_stream", s);
        chk("underrun_en_run", run_len(s), ERR_EN ? 19 : 18);
        chk("underrun_er_at_cut", cap_er[s + 18], ERR_EN);
        chk("underrun_er_count", count_ones(1'b1), ERR_EN ? 1 : 0);
        s3 = find_en(s + 19);
        chk("underrun_stray_dropped", s3, sx);
        exp_pre(7); exp_data(8'hC3, 1); exp_low(12);
        check_stream("underrun_next_frame", s3);
        $display("underrun: next frame at index %0d", s3);

        // Reset pulsed while data byte 20 is pending
        do_reset();
        s = cap_en.size();
        for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i), i == 0, 1'b0);
        chk("rst_before_tx_en", {gmii_tx_en, gmii_txd}, 9'h153);
        in_vld = 1'b1; in_data = 8'h54;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_done, in_rdy}, 13'h0);
        cycle();
        rst = 1'b0;
        rst_idx = cap_en.size();
        for (int i = 20; i < 40; i++) send_byte(8'h40 + 8'(i), 1'b0, i == 39);
        idle(3);
        send_frame(5, 8'h60, sx);
        idle(16);
        chk("rst_no_tx_until_sof", find_en(rst_idx), sx);
        exp_pre(7); exp_data(8'h60, 5); exp_low(12);
        check_stream("rst_next_frame", sx);
        chk("rst_er_count", count_ones(1'b1), 0);
        $display("reset_midframe: fresh frame at index %0d", sx);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
